// File: rtl/wave_mode_ctrl.sv
// Run-time waveform/frequency controller for the DA wave sender; all changes commit at a period boundary.
// Optional: define WAVE_FLAG3_EN to extend the advance sequence with wave_flag = 3 (full-ROM sweep).
module wave_mode_ctrl #(
  parameter int unsigned DWELL_PERIODS = 16,
  parameter int unsigned FREQ_STEP     = 8,
  parameter int unsigned FREQ_MAX      = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_wave,
  input  logic       key_freq_up,
  input  logic       key_freq_dn,
  input  logic       auto_en,
  input  logic [9:0] rd_addr,
  output logic [1:0] wave_flag,
  output logic [7:0] freq_adj,
  output logic       busy,
  output logic       period_tick
);

  localparam int unsigned DW  = 8;
  localparam int unsigned FW  = 10;
  localparam int unsigned SW  = 6;
  localparam int unsigned SW1 = SW + 1;
  localparam logic signed [SW:0] STEP_LIM = SW1'(31);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_prev_end;
  logic                  r_period_tick;
  logic                  r_busy;
  logic [1:0]            r_wave_flag;
  logic [7:0]            r_freq_adj;
  logic [DW-1:0]         r_dwell_cnt;
  logic                  r_pend_wave;
  logic                  r_pend_any;
  logic signed [SW-1:0]  r_pend_steps;

  logic                  w_at_end;
  logic                  w_boundary;
  logic                  w_expire;
  logic                  w_req_wave;
  logic                  w_req_any;
  logic signed [SW:0]    w_delta;
  logic signed [SW-1:0]  w_steps_base;
  logic signed [SW:0]    w_steps_sum;
  logic signed [SW-1:0]  w_steps_nxt;
  logic                  w_pend_wave_nxt;
  logic                  w_pend_any_nxt;
  logic signed [FW-1:0]  w_step_scaled;
  logic signed [FW-1:0]  w_freq_sum;
  logic [7:0]            w_freq_new;
  logic [1:0]            w_wave_next;
  logic                  w_unused_addr;

  // Boundary is the first cycle of an xFF run, so a held rd_addr yields one boundary per period
  assign w_at_end      = (rd_addr[7:0] == 8'hFF);
  assign w_boundary    = w_at_end & ~r_prev_end;
  assign w_expire      = auto_en & w_boundary & (r_dwell_cnt == DW'(DWELL_PERIODS - 1));
  assign w_req_wave    = key_wave | w_expire;
  assign w_req_any     = w_req_wave | key_freq_up | key_freq_dn;
  assign w_unused_addr = ^rd_addr[9:8];

  // Request latching; the COMMIT cycle starts a fresh set so its own requests carry to the next period
  always_comb begin
    w_delta = '0;
    if (key_freq_up & ~key_freq_dn) begin
      w_delta = SW1'(1);
    end else if (key_freq_dn & ~key_freq_up) begin
      w_delta = -SW1'(1);
    end

    w_steps_base = (r_state == S_COMMIT) ? '0 : r_pend_steps;
    w_steps_sum  = SW1'(w_steps_base) + w_delta;
    if (w_steps_sum > STEP_LIM) begin
      w_steps_nxt = SW'(STEP_LIM);
    end else if (w_steps_sum < -STEP_LIM) begin
      w_steps_nxt = SW'(-STEP_LIM);
    end else begin
      w_steps_nxt = SW'(w_steps_sum);
    end

    w_pend_wave_nxt = ((r_state != S_COMMIT) & r_pend_wave) | w_req_wave;
    w_pend_any_nxt  = ((r_state != S_COMMIT) & r_pend_any) | w_req_any;
  end

  // Saturating frequency update in 10-bit signed arithmetic
  always_comb begin
    w_step_scaled = FW'(r_pend_steps) * $signed(FW'(FREQ_STEP));
    w_freq_sum    = $signed({2'b00, r_freq_adj}) + w_step_scaled;
    if (w_freq_sum[FW-1]) begin
      w_freq_new = 8'd0;
    end else if (w_freq_sum > $signed(FW'(FREQ_MAX))) begin
      w_freq_new = 8'(FREQ_MAX);
    end else begin
      w_freq_new = w_freq_sum[7:0];
    end
  end

  always_comb begin
`ifdef WAVE_FLAG3_EN
    w_wave_next = r_wave_flag + 2'd1;
`else
    w_wave_next = (r_wave_flag == 2'd2) ? 2'd0 : r_wave_flag + 2'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_prev_end    <= 1'b0;
      r_period_tick <= 1'b0;
      r_busy        <= 1'b0;
      r_wave_flag   <= 2'd0;
      r_freq_adj    <= 8'd0;
      r_dwell_cnt   <= '0;
      r_pend_wave   <= 1'b0;
      r_pend_any    <= 1'b0;
      r_pend_steps  <= '0;
    end else begin
      r_prev_end    <= w_at_end;
      r_period_tick <= w_boundary;
      r_pend_wave   <= w_pend_wave_nxt;
      r_pend_any    <= w_pend_any_nxt;
      r_pend_steps  <= w_steps_nxt;

      if (!auto_en) begin
        r_dwell_cnt <= '0;
      end else if (w_boundary) begin
        r_dwell_cnt <= w_expire ? '0 : r_dwell_cnt + DW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_pend_any_nxt) begin
            r_state <= S_PENDING;
            r_busy  <= 1'b1;
          end
        end
        S_PENDING: begin
          if (w_boundary) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_freq_adj <= w_freq_new;
          if (r_pend_wave) begin
            r_wave_flag <= w_wave_next;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wave_flag   = r_wave_flag;
  assign freq_adj    = r_freq_adj;
  assign busy        = r_busy;
  assign period_tick = r_period_tick;

endmodule

// File: tb/tb_wave_mode_ctrl.sv
// Bench for wave_mode_ctrl: event-level reference model checked every cycle, plus directed literal checks.
module tb_wave_mode_ctrl;

  localparam int DWELL = 4;
  localparam int STEP  = 8;
  localparam int FMAX  = 255;
`ifdef WAVE_FLAG3_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_wave;
  logic       key_freq_up;
  logic       key_freq_dn;
  logic       auto_en;
  logic [9:0] rd_addr;
  logic [1:0] wave_flag;
  logic [7:0] freq_adj;
  logic       busy;
  logic       period_tick;

  int n_cmp = 0;
  int n_err = 0;
  int hold  = 1;
  int hcnt  = 0;
  bit chk_on = 0;

  // Reference model state (plain integers)
  int m_wave, m_freq, m_dwell, m_steps;
  bit m_busy, m_tick, m_ffprev, m_pwave, m_pany, m_waiting, m_apply;
  bit ff_now, bnd, expire, rq_wave, rq_any;
  int rq_delta;

  wave_mode_ctrl #(
    .DWELL_PERIODS(DWELL),
    .FREQ_STEP    (STEP),
    .FREQ_MAX     (FMAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_wave   (key_wave),
    .key_freq_up(key_freq_up),
    .key_freq_dn(key_freq_dn),
    .auto_en    (auto_en),
    .rd_addr    (rd_addr),
    .wave_flag  (wave_flag),
    .freq_adj   (freq_adj),
    .busy       (busy),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  function automatic int sat31(input int v);
    return (v > 31) ? 31 : ((v < -31) ? -31 : v);
  endfunction

  function automatic int clampf(input int v);
    return (v < 0) ? 0 : ((v > FMAX) ? FMAX : v);
  endfunction

  // Model: a change waits for the next period start, lands one cycle later
  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_wave = 0; m_freq = 0; m_dwell = 0; m_steps = 0;
      m_busy = 0; m_tick = 0; m_ffprev = 0; m_pwave = 0; m_pany = 0;
      m_waiting = 0; m_apply = 0;
    end else begin
      ff_now   = (rd_addr[7:0] == 8'hFF);
      bnd      = ff_now && !m_ffprev;
      m_ffprev = ff_now;
      expire   = 0;
      if (auto_en !== 1'b1) m_dwell = 0;
      else if (bnd) begin
        if (m_dwell == DWELL - 1) begin expire = 1; m_dwell = 0; end
        else m_dwell = m_dwell + 1;
      end
      rq_wave  = (key_wave === 1'b1) || expire;
      rq_delta = ((key_freq_up === 1'b1) ? 1 : 0) - ((key_freq_dn === 1'b1) ? 1 : 0);
      rq_any   = rq_wave || (key_freq_up === 1'b1) || (key_freq_dn === 1'b1);
      m_tick   = bnd;
      if (m_apply) begin
        if (m_pwave) m_wave = (m_wave + 1) % NW;
        m_freq    = clampf(m_freq + m_steps * STEP);
        m_busy    = 0;
        m_apply   = 0;
        m_waiting = 0;
        m_pwave   = rq_wave;
        m_steps   = rq_delta;
        m_pany    = rq_any;
      end else begin
        m_pwave = m_pwave || rq_wave;
        m_steps = sat31(m_steps + rq_delta);
        m_pany  = m_pany || rq_any;
        if (m_waiting && bnd) m_apply = 1;
        else if (!m_waiting && m_pany) begin m_waiting = 1; m_busy = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_cmp = n_cmp + 1;
      if (wave_flag !== 2'(m_wave) || freq_adj !== 8'(m_freq) ||
          busy !== m_busy || period_tick !== m_tick) begin
        n_err = n_err + 1;
        $display("FAIL model @%0t: wave %0d exp %0d, freq %0d exp %0d, busy %0b exp %0b, tick %0b exp %0b",
                 $time, wave_flag, m_wave, freq_adj, m_freq, busy, m_busy, period_tick, m_tick);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic kw, input logic ku, input logic kd);
    @(negedge clk);
    if (hcnt + 1 >= hold) begin
      hcnt    = 0;
      rd_addr = rd_addr + 10'd1;
    end else begin
      hcnt = hcnt + 1;
    end
    key_wave    = kw;
    key_freq_up = ku;
    key_freq_dn = kd;
  endtask

  // Step (hold = 1) until xFF is presented; kw rides on that same cycle
  task automatic go_boundary(input logic kw);
    int n = 0;
    while (8'(rd_addr + 10'd1) != 8'hFF && n < 2000) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 2000) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL go_boundary: got timeout expected xFF");
    end
    cyc(kw, 1'b0, 1'b0);
  endtask

  task automatic period();
    go_boundary(1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulses(input int n, input logic ku, input logic kd);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, ku, kd);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

`ifdef WAVE_FLAG3_EN
  int seq_before[4] = '{2, 3, 0, 1};
  int seq_after[4]  = '{3, 0, 1, 2};
`else
  int seq_before[4] = '{2, 0, 1, 2};
  int seq_after[4]  = '{0, 1, 2, 0};
`endif

  initial begin
    int ticks;
    rst_n = 1'b0; key_wave = 1'b1; key_freq_up = 1'b1; key_freq_dn = 1'b1;
    auto_en = 1'b0; rd_addr = 10'd250;
    repeat (3) @(negedge clk);
    chk_on = 1;
    rst_n = 1'b1; key_wave = 1'b0; key_freq_up = 1'b0; key_freq_dn = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst_wave", int'(wave_flag), 0);
    chk("rst_freq", int'(freq_adj), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(period_tick), 0);
    period();
    chk("rst_nolatch_busy", int'(busy), 0);
    chk("rst_nolatch_wave", int'(wave_flag), 0);

    // Wave switch lands 2 clks after rd_addr first reads xFF
    @(negedge clk); rd_addr = 10'd100;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t2_busy_now", int'(busy), 1);
    go_boundary(1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t2_tick", int'(period_tick), 1);
    chk("t2_wave_plus1", int'(wave_flag), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t2_wave_plus2", int'(wave_flag), 1);
    chk("t2_busy_drop", int'(busy), 0);

    // Frequency: step saturation, clamp high, clamp low
    pulses(40, 1'b1, 1'b0); period();
    chk("t3_steps_sat", int'(freq_adj), 248);
    pulses(3, 1'b1, 1'b0); period();
    chk("t3_clamp_hi", int'(freq_adj), 255);
    pulses(31, 1'b0, 1'b1); period();
    chk("t3_dn31", int'(freq_adj), 7);
    pulses(1, 1'b0, 1'b1); period();
    chk("t3_clamp_lo1", int'(freq_adj), 0);
    pulses(1, 1'b1, 1'b0); period();
    chk("t3_up1", int'(freq_adj), 8);
    pulses(2, 1'b0, 1'b1); period();
    chk("t3_clamp_lo2", int'(freq_adj), 0);

    // Simultaneous up+dn cancels but still raises busy
    pulses(1, 1'b1, 1'b0); period();
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t4_updn_busy", int'(busy), 1);
    period();
    chk("t4_updn_freq", int'(freq_adj), 8);

    // key_wave coincident with dwell expiry on the 4th boundary
    auto_en = 1'b1;
    repeat (3) period();
    go_boundary(1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t4_coinc_busy", int'(busy), 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t4_coinc_wave_hold", int'(wave_flag), 1);
    period();
    chk("t4_coinc_wave", int'(wave_flag), 2);

    // Auto-sweep advances once every DWELL periods
    for (int k = 0; k < 4; k++) begin
      repeat (3) period();
      chk("t5_before", int'(wave_flag), seq_before[k]);
      period();
      chk("t5_after", int'(wave_flag), seq_after[k]);
    end
    auto_en = 1'b0;

    // Slow sender: rd_addr held 3 clks per value
    @(negedge clk); rd_addr = 10'd10; hold = 3; hcnt = 0;
    ticks = 0;
    for (int i = 0; i < 1536; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (period_tick === 1'b1) ticks++;
    end
    chk("t6_slow_ticks", ticks, 2);

    // Reset while PENDING discards the request
    cyc(1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    chk("t6_pending", int'(busy), 1);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("t6_rst_busy", int'(busy), 0);
    repeat (900) cyc(1'b0, 1'b0, 1'b0);
    chk("t6_nocommit_freq", int'(freq_adj), 0);
    chk("t6_nocommit_busy", int'(busy), 0);
    chk("t6_nocommit_wave", int'(wave_flag), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
